// File: rtl/ht_init_ctrl.sv
// Clear sequencer and admission gate in front of the hash-table pipeline.
// Clears both table RAMs after reset or on request, and drains in-flight tasks before a requested clear.
module ht_init_ctrl #(
  parameter int MAX_INFLIGHT = 16,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             task_valid_i,
  output logic             task_ready_o,
  output logic             pipe_valid_o,
  input  logic             pipe_ready_i,
  input  logic             res_valid_i,
  input  logic             res_ready_i,
  input  logic             clear_req_i,
  output logic             head_clear_run_o,
  input  logic             head_clear_done_i,
  output logic             data_clear_run_o,
  input  logic             data_clear_done_i,
  output logic             busy_o,
  output logic             init_done_o,
  output logic [CNT_W-1:0] inflight_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           state_r;
  logic             h_seen_r;
  logic             d_seen_r;
  logic             busy_r;
  logic             init_done_r;
  logic             err_r;
  logic [CNT_W-1:0] cnt_r;

  logic gate_s;
  logic inc_s;
  logic dec_s;
  logic clr_done_s;
  logic run_pulse_s;

  assign gate_s       = (state_r == ST_RUN) && (cnt_r < CNT_W'(MAX_INFLIGHT));
  assign pipe_valid_o = task_valid_i & gate_s;
  assign task_ready_o = pipe_ready_i & gate_s;

  assign inc_s      = pipe_valid_o & pipe_ready_i;
  assign dec_s      = res_valid_i & res_ready_i;
  assign clr_done_s = (h_seen_r | head_clear_done_i) & (d_seen_r | data_clear_done_i);

  // START sits in the reset state, so the pulse is masked while reset is held.
  assign run_pulse_s      = (state_r == ST_START) & ~rst_i;
  assign head_clear_run_o = run_pulse_s;
  assign data_clear_run_o = run_pulse_s;

  assign busy_o      = busy_r;
  assign init_done_o = init_done_r;
  assign inflight_o  = cnt_r;
  assign err_o       = err_r;

  // Clear sequencer FSM; busy/init_done are registered from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_START;
      h_seen_r    <= 1'b0;
      d_seen_r    <= 1'b0;
      busy_r      <= 1'b1;
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_START: begin
          h_seen_r <= 1'b0;
          d_seen_r <= 1'b0;
          state_r  <= ST_CLEAR;
          busy_r   <= 1'b1;
        end
        ST_CLEAR: begin
          h_seen_r <= h_seen_r | head_clear_done_i;
          d_seen_r <= d_seen_r | data_clear_done_i;
          if (clr_done_s) begin
            state_r     <= ST_RUN;
            busy_r      <= 1'b0;
            init_done_r <= 1'b1;
          end else begin
            busy_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (clear_req_i) begin
            state_r <= ST_DRAIN;
            busy_r  <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_DRAIN: begin
          busy_r <= 1'b1;
          if (cnt_r == '0) begin
            state_r <= ST_START;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          state_r <= ST_START;
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // In-flight counter; a result with nothing outstanding is flagged, not counted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= '0;
      err_r <= 1'b0;
    end else begin
      case ({inc_s, dec_s})
        2'b10: cnt_r <= cnt_r + CNT_W'(1);
        2'b01: begin
          if (cnt_r == '0) begin
            err_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_ht_init_ctrl.sv
// Scoreboard bench for ht_init_ctrl: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_ht_init_ctrl;

  localparam int MAXF = 4;
  localparam int CW   = $clog2(MAXF + 1);

  localparam int ID_TR = 0, ID_PV = 1, ID_HR = 2, ID_DR = 3, ID_BUSY = 4,
                 ID_INIT = 5, ID_INFL = 6, ID_ERR = 7, ID_HP = 8, ID_DP = 9;

  typedef struct {
    int c;
    int id;
    int v;
  } exp_t;

  logic clk = 1'b0;
  logic rst, task_valid, task_ready, pipe_valid, pipe_ready;
  logic res_valid, res_ready, clear_req;
  logic head_run, head_done, data_run, data_done;
  logic busy, init_done, err;
  logic [CW-1:0] inflight;

  exp_t sb[$];
  int   cyc = 0;
  int   hp = 0;
  int   dp = 0;
  int   checks = 0;
  int   errors = 0;

  ht_init_ctrl #(.MAX_INFLIGHT(MAXF)) dut (
    .clk_i(clk), .rst_i(rst),
    .task_valid_i(task_valid), .task_ready_o(task_ready),
    .pipe_valid_o(pipe_valid), .pipe_ready_i(pipe_ready),
    .res_valid_i(res_valid), .res_ready_i(res_ready),
    .clear_req_i(clear_req),
    .head_clear_run_o(head_run), .head_clear_done_i(head_done),
    .data_clear_run_o(data_run), .data_clear_done_i(data_done),
    .busy_o(busy), .init_done_o(init_done), .inflight_o(inflight), .err_o(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sample(int id);
    case (id)
      ID_TR:   return int'(task_ready);
      ID_PV:   return int'(pipe_valid);
      ID_HR:   return int'(head_run);
      ID_DR:   return int'(data_run);
      ID_BUSY: return int'(busy);
      ID_INIT: return int'(init_done);
      ID_INFL: return int'(inflight);
      ID_ERR:  return int'(err);
      ID_HP:   return hp;
      ID_DP:   return dp;
      default: return -1;
    endcase
  endfunction

  function automatic string nm(int id);
    case (id)
      ID_TR:   return "task_ready";
      ID_PV:   return "pipe_valid";
      ID_HR:   return "head_run";
      ID_DR:   return "data_run";
      ID_BUSY: return "busy";
      ID_INIT: return "init_done";
      ID_INFL: return "inflight";
      ID_ERR:  return "err";
      ID_HP:   return "head_pulses";
      ID_DP:   return "data_pulses";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: count run pulses, then pop and compare every expectation due this cycle.
  always @(negedge clk) begin
    exp_t e;
    int   act;
    if (head_run === 1'b1) hp = hp + 1;
    if (data_run === 1'b1) dp = dp + 1;
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      e   = sb.pop_front();
      act = sample(e.id);
      checks = checks + 1;
      if (act !== e.v) begin
        errors = errors + 1;
        $display("FAIL %s cycle_tag=%0d actual=%0d expected=%0d", nm(e.id), e.c, act, e.v);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input int id, input int v);
    exp_t e;
    e.c  = cyc;
    e.id = id;
    e.v  = v;
    sb.push_back(e);
  endtask

  task automatic chk_all(input int tr, input int pv, input int hr, input int dr,
                         input int bz, input int ini, input int infl, input int er);
    ex(ID_TR, tr); ex(ID_PV, pv); ex(ID_HR, hr); ex(ID_DR, dr);
    ex(ID_BUSY, bz); ex(ID_INIT, ini); ex(ID_INFL, infl); ex(ID_ERR, er);
  endtask

  initial begin
    rst = 1'b1; task_valid = 1'b1; pipe_ready = 1'b1;
    res_valid = 1'b0; res_ready = 1'b1; clear_req = 1'b0;
    head_done = 1'b0; data_done = 1'b0;

    // Reset state with upstream valid and pipe ready both high
    step; step; chk_all(0, 0, 0, 0, 1, 0, 0, 0);

    // Cycle 0: release, run pulses
    step; rst = 1'b0; chk_all(0, 0, 1, 1, 1, 0, 0, 0);
    // Cycles 1..9: head done in 5, data done in 9
    for (int c = 1; c <= 9; c++) begin
      step;
      head_done = (c == 5);
      data_done = (c == 9);
      chk_all(0, 0, 0, 0, 1, 0, 0, 0);
    end
    // Cycle 10: RUN, admission opens; fill to MAX_INFLIGHT
    step; data_done = 1'b0; chk_all(1, 1, 0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      step; chk_all(1, 1, 0, 0, 0, 1, k, 0);
    end
    step; chk_all(0, 0, 0, 0, 0, 1, 4, 0); ex(ID_HP, 1); ex(ID_DP, 1);   // 14: full
    step; res_valid = 1'b1; chk_all(0, 0, 0, 0, 0, 1, 4, 0);             // 15: one result
    step; res_valid = 1'b0; task_valid = 1'b0; chk_all(1, 0, 0, 0, 0, 1, 3, 0); // 16: resumes
    step; res_valid = 1'b1; chk_all(1, 0, 0, 0, 0, 1, 3, 0);             // 17: 3 -> 2
    step; task_valid = 1'b1; chk_all(1, 1, 0, 0, 0, 1, 2, 0);            // 18: accept + result
    step; res_valid = 1'b0; chk_all(1, 1, 0, 0, 0, 1, 2, 0);             // 19: still 2, err 0
    step; task_valid = 1'b0; clear_req = 1'b1; chk_all(1, 0, 0, 0, 0, 1, 3, 0); // 20: clear req
    step; clear_req = 1'b0; task_valid = 1'b1; chk_all(0, 0, 0, 0, 1, 1, 3, 0); // 21: DRAIN
    step; clear_req = 1'b1; res_valid = 1'b1; chk_all(0, 0, 0, 0, 1, 1, 3, 0);  // 22: coalesced req
    step; clear_req = 1'b0; chk_all(0, 0, 0, 0, 1, 1, 2, 0);             // 23
    step; chk_all(0, 0, 0, 0, 1, 1, 1, 0);                               // 24
    step; res_valid = 1'b0; chk_all(0, 0, 0, 0, 1, 1, 0, 0);             // 25: drained
    step; chk_all(0, 0, 1, 1, 1, 1, 0, 0);                               // 26: START
    step; head_done = 1'b1; data_done = 1'b1;
    chk_all(0, 0, 0, 0, 1, 1, 0, 0); ex(ID_HP, 2); ex(ID_DP, 2);         // 27: CLEAR
    step; head_done = 1'b0; data_done = 1'b0; task_valid = 1'b0; res_valid = 1'b1;
    chk_all(1, 0, 0, 0, 0, 1, 0, 0);                                     // 28: RUN, stray result
    step; res_valid = 1'b0; chk_all(1, 0, 0, 0, 0, 1, 0, 1);             // 29: err set
    step; task_valid = 1'b1; chk_all(1, 1, 0, 0, 0, 1, 0, 1);            // 30
    step; chk_all(1, 1, 0, 0, 0, 1, 1, 1);                               // 31
    step; task_valid = 1'b0; clear_req = 1'b1; chk_all(1, 0, 0, 0, 0, 1, 2, 1); // 32
    step; clear_req = 1'b0; chk_all(0, 0, 0, 0, 1, 1, 2, 1);             // 33: DRAIN, 2 in flight
    step; rst = 1'b1; chk_all(0, 0, 0, 0, 1, 0, 0, 0);                   // 34: async reset
    step; chk_all(0, 0, 0, 0, 1, 0, 0, 0);                               // 35
    step; rst = 1'b0; head_done = 1'b1; data_done = 1'b1;
    chk_all(0, 0, 1, 1, 1, 0, 0, 0); ex(ID_HP, 3); ex(ID_DP, 3);         // 36: fresh START
    step; chk_all(0, 0, 0, 0, 1, 0, 0, 0);                               // 37: held done
    step; head_done = 1'b0; data_done = 1'b0; chk_all(1, 0, 0, 0, 0, 1, 0, 0); // 38: RUN

    for (int w = 0; w < 10 && sb.size() > 0; w++) step;
    if (sb.size() > 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
